// File: rtl/risc_v_pkg.sv
// Shared constants for the RISC-V memory arbiter: FSM encoding, store size
// codes and grant identifiers.
package risc_v_pkg;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  localparam logic [2:0] SZ_BYTE = 3'd1;
  localparam logic [2:0] SZ_HALF = 3'd3;
  localparam logic [2:0] SZ_WORD = 3'd7;

  localparam logic GNT_FETCH = 1'b0;
  localparam logic GNT_DATA  = 1'b1;

endpackage

// File: rtl/risc_v_mem_arbiter_if.sv
// Bus bundle between core requesters, the arbiter and the shared memory.
interface risc_v_mem_arbiter_if #(parameter int WORD_LENGTH = 32);

  logic                   if_req;
  logic [WORD_LENGTH-1:0] if_addr;
  logic                   if_valid;
  logic [WORD_LENGTH-1:0] if_rdata;
  logic                   if_err;
  logic                   mem_read_en;
  logic [2:0]             mem_write_en;
  logic [WORD_LENGTH-1:0] d_addr;
  logic [WORD_LENGTH-1:0] d_wdata;
  logic                   d_valid;
  logic [WORD_LENGTH-1:0] d_rdata;
  logic                   d_err;
  logic                   stall;
  logic                   mem_req;
  logic                   mem_we;
  logic [3:0]             mem_be;
  logic [WORD_LENGTH-1:0] mem_addr;
  logic [WORD_LENGTH-1:0] mem_wdata;
  logic                   mem_ready;
  logic [WORD_LENGTH-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr, mem_read_en, mem_write_en, d_addr, d_wdata,
           mem_ready, mem_rdata,
    output if_valid, if_rdata, if_err, d_valid, d_rdata, d_err, stall,
           mem_req, mem_we, mem_be, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, mem_read_en, mem_write_en, d_addr, d_wdata,
           mem_ready, mem_rdata,
    input  if_valid, if_rdata, if_err, d_valid, d_rdata, d_err, stall,
           mem_req, mem_we, mem_be, mem_addr, mem_wdata
  );

endinterface

// File: rtl/risc_v_store_align.sv
// Store size decode: byte enables, lane-replicated write data and misalignment.
module risc_v_store_align
  import risc_v_pkg::*;
(
  input  logic [2:0]  size_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic        misaligned_o
);

  always_comb begin
    be_o         = 4'b0000;
    wdata_o      = wdata_i;
    misaligned_o = 1'b0;
    case (size_i)
      SZ_BYTE: begin
        be_o    = 4'b0001 << addr_lo_i;
        wdata_o = {4{wdata_i[7:0]}};
      end
      SZ_HALF: begin
        be_o         = 4'b0011 << addr_lo_i;
        wdata_o      = {2{wdata_i[15:0]}};
        misaligned_o = addr_lo_i[0];
      end
      SZ_WORD: begin
        be_o         = 4'b1111;
        misaligned_o = |addr_lo_i;
      end
      default: be_o = 4'b0000;
    endcase
  end

endmodule

// File: rtl/risc_v_mem_arbiter.sv
// Shares one single-port memory between instruction fetch and load/store,
// with alternating priority and a wait-state watchdog.
//   state | meaning
//   IDLE  | no access in flight, arbitrate pending requests
//   FETCH | fetch access on the memory bus, waiting for mem_ready
//   DATA  | load/store access on the memory bus, waiting for mem_ready
//   RESP  | one-cycle valid pulse to the granted requester
module risc_v_mem_arbiter
  import risc_v_pkg::*;
#(
  parameter int WORD_LENGTH    = 32,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 7
) (
  input  logic                   clk,
  input  logic                   rst_n,
  risc_v_mem_arbiter_if.slave    bus
);

  logic [1:0]             state_q, state_d;
  logic                   last_grant_q, last_grant_d;
  logic                   grant_q, grant_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   mem_req_q, mem_req_d;
  logic                   we_q, we_d;
  logic [3:0]             be_q, be_d;
  logic [WORD_LENGTH-1:0] addr_q, addr_d;
  logic [WORD_LENGTH-1:0] wdata_q, wdata_d;
  logic [WORD_LENGTH-1:0] rdata_q, rdata_d;
  logic                   err_q, err_d;

  logic                   is_store, d_req, pick_data;
  logic [3:0]             al_be;
  logic [31:0]            al_wdata;
  logic                   al_mis;
  logic [CNT_W-1:0]       cnt_inc;

  risc_v_store_align u_align (
    .size_i       (bus.mem_write_en),
    .addr_lo_i    (bus.d_addr[1:0]),
    .wdata_i      (bus.d_wdata),
    .be_o         (al_be),
    .wdata_o      (al_wdata),
    .misaligned_o (al_mis)
  );

  assign is_store  = bus.mem_write_en != 3'd0;
  assign d_req     = bus.mem_read_en | is_store;
  assign pick_data = d_req & (~bus.if_req | (last_grant_q == GNT_FETCH));
  assign cnt_inc   = cnt_q + CNT_W'(1);

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    cnt_d        = cnt_q;
    mem_req_d    = mem_req_q;
    we_d         = we_q;
    be_d         = be_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    err_d        = err_q;
    case (state_q)
      S_IDLE: begin
        if (pick_data) begin
          grant_d = GNT_DATA;
          if (is_store && al_mis) begin
            // misaligned stores are answered without touching memory
            state_d = S_RESP;
            err_d   = 1'b1;
            rdata_d = '0;
          end else begin
            state_d      = S_DATA;
            last_grant_d = GNT_DATA;
            mem_req_d    = 1'b1;
            addr_d       = {bus.d_addr[WORD_LENGTH-1:2], 2'b00};
            we_d         = is_store;
            be_d         = is_store ? al_be : 4'b1111;
            wdata_d      = is_store ? al_wdata : '0;
            err_d        = 1'b0;
            cnt_d        = '0;
          end
        end else if (bus.if_req) begin
          state_d      = S_FETCH;
          grant_d      = GNT_FETCH;
          last_grant_d = GNT_FETCH;
          mem_req_d    = 1'b1;
          addr_d       = bus.if_addr;
          we_d         = 1'b0;
          be_d         = 4'b1111;
          wdata_d      = '0;
          err_d        = 1'b0;
          cnt_d        = '0;
        end
      end
      S_FETCH, S_DATA: begin
        if (bus.mem_ready) begin
          state_d   = S_RESP;
          mem_req_d = 1'b0;
          rdata_d   = bus.mem_rdata;
          err_d     = 1'b0;
        end else if (cnt_inc == CNT_W'(TIMEOUT_CYCLES)) begin
          state_d   = S_RESP;
          mem_req_d = 1'b0;
          rdata_d   = '0;
          err_d     = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      last_grant_q <= GNT_FETCH;
      grant_q      <= GNT_FETCH;
      cnt_q        <= '0;
      mem_req_q    <= 1'b0;
      we_q         <= 1'b0;
      be_q         <= 4'b0000;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      cnt_q        <= cnt_d;
      mem_req_q    <= mem_req_d;
      we_q         <= we_d;
      be_q         <= be_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
    end
  end

  assign bus.if_valid  = (state_q == S_RESP) && (grant_q == GNT_FETCH);
  assign bus.d_valid   = (state_q == S_RESP) && (grant_q == GNT_DATA);
  assign bus.if_rdata  = bus.if_valid ? rdata_q : '0;
  assign bus.d_rdata   = bus.d_valid ? rdata_q : '0;
  assign bus.if_err    = bus.if_valid & err_q;
  assign bus.d_err     = bus.d_valid & err_q;
  assign bus.stall     = (bus.if_req & ~bus.if_valid) | (d_req & ~bus.d_valid);
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_req_q & we_q;
  assign bus.mem_be    = be_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;

endmodule

// File: tb/tb_risc_v_mem_arbiter.sv
// Directed self-checking bench for risc_v_mem_arbiter (TIMEOUT_CYCLES=4).
module tb_risc_v_mem_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  risc_v_mem_arbiter_if #(.WORD_LENGTH(32)) bus ();

  risc_v_mem_arbiter #(
    .WORD_LENGTH    (32),
    .TIMEOUT_CYCLES (4),
    .CNT_W          (3)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.if_req       = 1'b0;
    bus.if_addr      = '0;
    bus.mem_read_en  = 1'b0;
    bus.mem_write_en = 3'd0;
    bus.d_addr       = '0;
    bus.d_wdata      = '0;
    bus.mem_ready    = 1'b0;
    bus.mem_rdata    = '0;
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    chk("rst_mem_req", bus.mem_req, 0);
    chk("rst_if_valid", bus.if_valid, 0);
    chk("rst_d_valid", bus.d_valid, 0);
    chk("rst_stall", bus.stall, 0);
    chk("rst_mem_be", bus.mem_be, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    rst_n = 1'b1;
    tick();

    // zero-wait fetch
    bus.if_req = 1'b1; bus.if_addr = 32'h100;
    bus.mem_ready = 1'b1; bus.mem_rdata = 32'h0000_0013;
    #1 chk("fetch_stall_req", bus.stall, 1);
    tick();
    chk("fetch_mem_req", bus.mem_req, 1);
    chk("fetch_mem_addr", bus.mem_addr, 32'h100);
    chk("fetch_mem_be", bus.mem_be, 4'hF);
    chk("fetch_mem_we", bus.mem_we, 0);
    chk("fetch_no_valid_yet", bus.if_valid, 0);
    chk("fetch_stall_wait", bus.stall, 1);
    tick();
    chk("fetch_valid", bus.if_valid, 1);
    chk("fetch_rdata", bus.if_rdata, 32'h0000_0013);
    chk("fetch_err", bus.if_err, 0);
    chk("fetch_req_drop", bus.mem_req, 0);
    chk("fetch_stall_done", bus.stall, 0);
    idle_inputs();
    tick();
    chk("fetch_valid_one_cycle", bus.if_valid, 0);

    // byte store at 0x203 with one wait state
    bus.mem_write_en = 3'd1; bus.d_addr = 32'h203; bus.d_wdata = 32'h0000_00AB;
    tick();
    chk("sb_mem_req", bus.mem_req, 1);
    chk("sb_mem_be", bus.mem_be, 4'b1000);
    chk("sb_mem_addr", bus.mem_addr, 32'h200);
    chk("sb_mem_wdata", bus.mem_wdata, 32'hABAB_ABAB);
    chk("sb_mem_we", bus.mem_we, 1);
    tick();
    chk("sb_still_waiting", bus.mem_req, 1);
    bus.mem_ready = 1'b1;
    tick();
    chk("sb_d_valid", bus.d_valid, 1);
    chk("sb_d_err", bus.d_err, 0);
    idle_inputs();
    tick();

    // aligned half store at 0x202
    bus.mem_write_en = 3'd3; bus.d_addr = 32'h202; bus.d_wdata = 32'hFFFF_1234;
    bus.mem_ready = 1'b1;
    tick();
    chk("sh_mem_be", bus.mem_be, 4'b1100);
    chk("sh_mem_wdata", bus.mem_wdata, 32'h1234_1234);
    chk("sh_mem_addr", bus.mem_addr, 32'h200);
    tick();
    chk("sh_d_valid", bus.d_valid, 1);
    idle_inputs();
    tick();

    // misaligned half store: error response without a memory cycle
    bus.mem_write_en = 3'd3; bus.d_addr = 32'h201; bus.d_wdata = 32'h0000_5555;
    bus.mem_ready = 1'b1; bus.mem_rdata = 32'hDEAD_BEEF;
    tick();
    chk("mis_no_mem_req", bus.mem_req, 0);
    chk("mis_d_valid", bus.d_valid, 1);
    chk("mis_d_err", bus.d_err, 1);
    chk("mis_d_rdata", bus.d_rdata, 0);
    idle_inputs();
    tick();
    chk("mis_valid_one_cycle", bus.d_valid, 0);

    // both requesters from reset: D,F,D,F
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    bus.if_req = 1'b1; bus.if_addr = 32'h400;
    bus.mem_read_en = 1'b1; bus.d_addr = 32'h82;
    bus.mem_ready = 1'b1; bus.mem_rdata = 32'hCAFE_0001;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("alt_addr", bus.mem_addr, (i % 2 == 0) ? 32'h80 : 32'h400);
      tick();
      chk("alt_d_valid", bus.d_valid, (i % 2 == 0) ? 1 : 0);
      chk("alt_if_valid", bus.if_valid, (i % 2 == 0) ? 0 : 1);
      if (i % 2 == 0) chk("alt_d_rdata", bus.d_rdata, 32'hCAFE_0001);
      tick();
    end
    idle_inputs();
    tick();

    // fetch timeout: memory never answers
    bus.if_req = 1'b1; bus.if_addr = 32'h500; bus.mem_rdata = 32'h1111_2222;
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("to_mem_req_held", bus.mem_req, 1);
      chk("to_no_valid", bus.if_valid, 0);
      tick();
    end
    chk("to_mem_req_drop", bus.mem_req, 0);
    chk("to_if_valid", bus.if_valid, 1);
    chk("to_if_err", bus.if_err, 1);
    chk("to_if_rdata", bus.if_rdata, 0);
    idle_inputs();
    tick();

    // mem_ready in the last wait cycle beats the timeout
    bus.if_req = 1'b1; bus.if_addr = 32'h504;
    tick();
    tick();
    tick();
    tick();
    chk("late_mem_req", bus.mem_req, 1);
    bus.mem_ready = 1'b1; bus.mem_rdata = 32'h0000_0077;
    tick();
    chk("late_if_valid", bus.if_valid, 1);
    chk("late_if_err", bus.if_err, 0);
    chk("late_if_rdata", bus.if_rdata, 32'h0000_0077);
    idle_inputs();
    tick();

    // reset during a data wait abandons the access
    bus.mem_read_en = 1'b1; bus.d_addr = 32'h600;
    tick();
    chk("rmid_mem_req", bus.mem_req, 1);
    tick();
    rst_n = 1'b0;
    tick();
    chk("rmid_req_drop", bus.mem_req, 0);
    chk("rmid_no_d_valid", bus.d_valid, 0);
    chk("rmid_stall_held", bus.stall, 1);
    bus.mem_read_en = 1'b0;
    tick();
    chk("rmid_no_d_valid2", bus.d_valid, 0);
    chk("rmid_stall_free", bus.stall, 0);
    rst_n = 1'b1;
    bus.if_req = 1'b1; bus.if_addr = 32'h100;
    bus.mem_read_en = 1'b1; bus.d_addr = 32'h604;
    bus.mem_ready = 1'b1; bus.mem_rdata = 32'h0000_0055;
    tick();
    chk("rmid_data_first", bus.mem_addr, 32'h604);
    chk("rmid_load_we", bus.mem_we, 0);
    tick();
    chk("rmid_d_valid", bus.d_valid, 1);
    chk("rmid_d_rdata", bus.d_rdata, 32'h0000_0055);
    idle_inputs();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/risc_v_mem_arbiter.md
Name: risc_v_mem_arbiter

Overview:
- Sequences one shared single-port memory between the instruction-fetch requester and the load/store requester of the RISC-V core.
- Driven by the decoder's mem_read_en and mem_write_en (size code 1=byte, 3=half, 7=word). Generates byte enables and lane-replicated write data.
- Produces a stall to the core while a request is outstanding.
- Runs a timeout watchdog so a hung memory cannot lock the core.

Parameters:
- WORD_LENGTH, 32, data/address width in bits (must be 32).
- TIMEOUT_CYCLES, 64, wait-state cycles before a transaction is aborted.
- CNT_W, 7, width of the timeout counter (≥ clog2(TIMEOUT_CYCLES+1)).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  synchronous reset, active low.
- if_req  in  1  fetch request; held until if_valid.
- if_addr  in  WORD_LENGTH  fetch address, word aligned.
- if_valid  out  1  one-cycle pulse: fetch complete.
- if_rdata  out  WORD_LENGTH  fetched instruction, valid with if_valid.
- mem_read_en  in  1  load request; held until d_valid.
- mem_write_en  in  3  store size code 0/1/3/7; held until d_valid.
- d_addr  in  WORD_LENGTH  load/store byte address.
- d_wdata  in  WORD_LENGTH  store data in low bits.
- d_valid  out  1  one-cycle pulse: data access complete.
- d_rdata  out  WORD_LENGTH  raw load word, valid with d_valid.
- d_err  out  1  pulse with d_valid: misaligned or timed out.
- if_err  out  1  pulse with if_valid: timed out.
- stall  out  1  combinational: (if_req & ~if_valid) | (d_req & ~d_valid), where d_req = mem_read_en | (mem_write_en != 0).
- mem_req  out  1  memory request, registered.
- mem_we  out  1  write strobe.
- mem_be  out  4  byte enables.
- mem_addr  out  WORD_LENGTH  word address, {d_addr[31:2],2'b00} or if_addr.
- mem_wdata  out  WORD_LENGTH  lane-replicated store data.
- mem_ready  in  1  memory completes the access this cycle; mem_rdata valid.
- mem_rdata  in  WORD_LENGTH  read data.

Behaviour:
- Reset (rst_n=0 at an edge): state=IDLE, last_grant=FETCH, counter=0. All outputs 0.
- Reset mid-transaction: mem_req drops at that edge and the access is abandoned; no valid pulse is issued.
- FSM states: IDLE, FETCH, DATA, RESP.
- IDLE, grant:
  - Only d_req pending: grant data. Only if_req pending: grant fetch.
  - Both pending: grant the requester other than last_grant. Data therefore wins after reset.
  - On grant: latch address, we, be and wdata. Set mem_req=1 and last_grant. Go to FETCH or DATA.
- IDLE, misaligned data request (no grant issued):
  - Misaligned means half with d_addr[0]=1, or word with d_addr[1:0]≠0.
  - Go directly to RESP with d_err=1 and d_rdata=0. No memory cycle.
- Load with mem_write_en≠0 simultaneously: treat as a store. Size-code error is not possible, since codes 2/4/5/6 map to byte enables 0000 and the transfer completes as a write with no bytes.
- Byte enables:
  - byte: 0001<<d_addr[1:0], wdata={4{d_wdata[7:0]}}.
  - half: 0011<<d_addr[1:0], wdata={2{d_wdata[15:0]}}.
  - word: 1111, wdata=d_wdata.
  - load/fetch: be=1111, we=0.
- FETCH/DATA:
  - mem_req held with stable outputs until mem_ready=1.
  - On mem_ready: capture mem_rdata, drop mem_req, go to RESP.
  - Counter increments each wait cycle. When the counter reaches TIMEOUT_CYCLES without mem_ready: drop mem_req, rdata=0, err=1, go to RESP.
  - mem_ready and timeout in the same cycle: mem_ready wins, no error.
- RESP: pulse if_valid or d_valid (plus err) for exactly one cycle, clear the counter, return to IDLE.
  - A new grant can occur in the IDLE cycle that follows.
- Latency with a zero-wait memory (mem_ready in the first mem_req cycle): request seen at edge N, mem_req high during cycle N+1, valid high during cycle N+2. Three cycles from request to valid.
- A requester that drops its req mid-transaction does not cancel the access; the valid pulse is still issued.
- mem_ready while mem_req=0 is ignored.

Decomposition:
- Shared package risc_v_pkg holds:
  - FSM state encoding.
  - Size-code constants SZ_BYTE=1, SZ_HALF=3, SZ_WORD=7.
  - Grant-ID constants GNT_FETCH and GNT_DATA.
- One sub-module, risc_v_store_align (combinational): inputs size code, addr[1:0], wdata; outputs be, replicated wdata, misaligned flag.

Test Plan:
- Reset, then if_req=1, if_addr=0x100, memory returns 0x00000013 with zero wait → mem_addr=0x100, be=1111, if_valid with if_rdata=0x00000013 two cycles after mem_req rises. stall high until then.
- Store byte: mem_write_en=1, d_addr=0x203, d_wdata=0xAB → mem_be=1000, mem_addr=0x200, mem_wdata=0xABABABAB, mem_we=1, d_valid, d_err=0.
- Store half at d_addr=0x201 → no mem_req ever; d_valid with d_err=1 and d_rdata=0 two cycles after the request.
- if_req and mem_read_en raised together from reset → data granted first, then fetch. With both held continuously, grants alternate D,F,D,F.
- Memory never asserts mem_ready, TIMEOUT_CYCLES=4 → mem_req drops after 4 wait cycles, then if_valid+if_err with if_rdata=0. mem_ready arriving in the 4th wait cycle → normal completion, no error.
- rst_n=0 during the DATA wait → mem_req=0 and stall follows inputs after the edge. No d_valid is issued. Next request is served normally, with data priority restored.
